// File: rtl/fetch_prefetch.sv
// Instruction prefetch stage: credit-limited sequential word fetch feeding the instruction queue.
// state | meaning
// IDLE  | no request on the bus; waiting for credit, outstanding-slot and fetch enable
// REQ   | imem_req asserted at fetch_pc, held stable until granted
module fetch_prefetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          QDEPTH    = 4,
    parameter int          MAX_OUTST = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        fetch_en,
    input  logic        redirect_vld,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        q_wen,
    output logic [63:0] q_wdata,
    output logic        q_flush,
    input  logic        q_deq
);

    localparam int          CW          = $clog2(QDEPTH + 1);
    localparam logic [31:0] QDEPTH_U    = 32'(QDEPTH);
    localparam logic [31:0] MAX_OUTST_U = 32'(MAX_OUTST);

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] occ_cnt;
    logic [CW-1:0] outst_cnt;
    logic [CW-1:0] discard_cnt;

    logic [31:0]   occ_w;
    logic [31:0]   outst_w;
    logic [31:0]   credit_used;
    logic          can_issue;
    logic          can_issue_after;
    logic          gnt_fire;
    logic          rsp_live;
    logic          deq_live;
    logic [31:0]   redirect_pc_al;
    logic          unused_bits;

    assign unused_bits    = ^redirect_pc[1:0];
    assign redirect_pc_al = {redirect_pc[31:2], 2'b00};

    // Queue entries and in-flight requests share the same credit pool.
    assign occ_w           = 32'(occ_cnt);
    assign outst_w         = 32'(outst_cnt);
    assign credit_used     = occ_w + outst_w;
    assign can_issue       = fetch_en && (credit_used < QDEPTH_U) && (outst_w < MAX_OUTST_U);
    assign can_issue_after = fetch_en && ((credit_used + 32'd1) < QDEPTH_U)
                             && ((outst_w + 32'd1) < MAX_OUTST_U);

    assign imem_req  = (state == REQ) && !redirect_vld;
    assign imem_addr = fetch_pc;
    assign gnt_fire  = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_live = imem_rvalid && (outst_cnt != '0);
    assign deq_live = q_deq && (occ_cnt != '0);
    assign q_wen    = rsp_live && !redirect_vld && (discard_cnt == '0);
    assign q_wdata  = q_wen ? {resp_pc, imem_rdata} : 64'd0;
    assign q_flush  = redirect_vld && !RST;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            occ_cnt     <= '0;
            outst_cnt   <= '0;
            discard_cnt <= '0;
        end else begin
            if (redirect_vld) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE:    if (can_issue) state <= REQ;
                    REQ:     if (gnt_fire && !can_issue_after) state <= IDLE;
                    default: state <= IDLE;
                endcase
            end

            if (redirect_vld)  fetch_pc <= redirect_pc_al;
            else if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;

            if (redirect_vld) resp_pc <= redirect_pc_al;
            else if (q_wen)   resp_pc <= resp_pc + 32'd4;

            case ({gnt_fire, rsp_live})
                2'b10:   outst_cnt <= outst_cnt + CW'(1);
                2'b01:   outst_cnt <= outst_cnt - CW'(1);
                default: outst_cnt <= outst_cnt;
            endcase

            if (redirect_vld) begin
                occ_cnt <= '0;
            end else begin
                case ({q_wen, deq_live})
                    2'b10:   occ_cnt <= occ_cnt + CW'(1);
                    2'b01:   occ_cnt <= occ_cnt - CW'(1);
                    default: occ_cnt <= occ_cnt;
                endcase
            end

            // Everything still in flight at a redirect belongs to the old stream.
            if (redirect_vld)
                discard_cnt <= outst_cnt - CW'(rsp_live);
            else if (rsp_live && (discard_cnt != '0))
                discard_cnt <= discard_cnt - CW'(1);
        end
    end

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with an in-order memory model answering one cycle after grant.
module tb_fetch_prefetch;

    localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_vld = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        q_wen;
    logic [63:0] q_wdata;
    logic        q_flush;
    logic        q_deq = 1'b0;

    logic [31:0] pend[$];
    logic [31:0] req_log[$];
    logic [63:0] wen_log[$];
    int          n_flush;
    bit          rsp_en;
    logic        last_req, last_wen, last_flush;
    logic [31:0] last_addr;
    int          vec_cnt = 0;
    int          miss_cnt = 0;

    fetch_prefetch #(.RESET_PC(32'h0000_0000), .QDEPTH(4), .MAX_OUTST(2)) dut (
        .CLK(CLK), .RST(RST), .fetch_en(fetch_en),
        .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .q_wen(q_wen), .q_wdata(q_wdata), .q_flush(q_flush), .q_deq(q_deq)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ent(input logic [31:0] pc);
        return {pc, pc ^ MAGIC};
    endfunction

    function automatic logic [63:0] req_at(input int i);
        return (req_log.size() > i) ? {32'd0, req_log[i]} : '1;
    endfunction

    function automatic logic [63:0] wen_at(input int i);
        return (wen_log.size() > i) ? wen_log[i] : '1;
    endfunction

    task automatic clear_logs();
        req_log.delete();
        wen_log.delete();
        n_flush = 0;
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cyc();
        if (rsp_en && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0] ^ MAGIC;
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = 32'd0;
        end
        #1;
        last_req   = imem_req;
        last_addr  = imem_addr;
        last_wen   = q_wen;
        last_flush = q_flush;
        if (imem_req && imem_gnt) begin
            pend.push_back(imem_addr);
            req_log.push_back(imem_addr);
        end
        if (q_wen) wen_log.push_back(q_wdata);
        if (q_flush) n_flush++;
        @(negedge CLK);
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_vld = 1'b1;
        redirect_pc  = pc;
        cyc();
        redirect_vld = 1'b0;
    endtask

    initial begin
        clear_logs();
        rsp_en = 1'b0;
        #1 RST = 1'b1;
        #1;
        chk("rst_req",   {63'd0, imem_req}, 64'd0);
        chk("rst_addr",  {32'd0, imem_addr}, 64'd0);
        chk("rst_wen",   {63'd0, q_wen}, 64'd0);
        chk("rst_wdata", q_wdata, 64'd0);
        chk("rst_flush", {63'd0, q_flush}, 64'd0);

        // Fill from reset: credits run out after four fetches.
        @(negedge CLK);
        RST = 1'b0;
        fetch_en = 1'b1;
        imem_gnt = 1'b1;
        rsp_en   = 1'b1;
        run(12);
        chk("fill_nreq", 64'(req_log.size()), 64'd4);
        chk("fill_req0", req_at(0), 64'h0);
        chk("fill_req1", req_at(1), 64'h4);
        chk("fill_req3", req_at(3), 64'hC);
        chk("fill_nwen", 64'(wen_log.size()), 64'd4);
        chk("fill_wen0", wen_at(0), ent(32'h0));
        chk("fill_wen1", wen_at(1), ent(32'h4));
        chk("fill_wen2", wen_at(2), ent(32'h8));
        chk("fill_wen3", wen_at(3), ent(32'hC));
        run(3);
        chk("full_noreq", {63'd0, last_req}, 64'd0);
        chk("full_nreq",  64'(req_log.size()), 64'd4);

        // One dequeue frees exactly one credit.
        clear_logs();
        q_deq = 1'b1;
        cyc();
        q_deq = 1'b0;
        run(6);
        chk("deq_nreq", 64'(req_log.size()), 64'd1);
        chk("deq_req0", req_at(0), 64'h10);
        chk("deq_nwen", 64'(wen_log.size()), 64'd1);
        chk("deq_wen0", wen_at(0), ent(32'h10));

        // Request held stable without grant, even after fetch_en drops.
        RST = 1'b1;
        pend.delete();
        imem_gnt = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        clear_logs();
        cyc();
        chk("hold_idle", {63'd0, last_req}, 64'd0);
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_req",  {63'd0, last_req}, 64'd1);
            chk("hold_addr", {32'd0, last_addr}, 64'h0);
        end
        imem_gnt = 1'b1;
        cyc();
        chk("hold_gnt_req", {63'd0, last_req}, 64'd1);
        run(5);
        chk("hold_nreq", 64'(req_log.size()), 64'd1);
        chk("hold_wen0", wen_at(0), ent(32'h0));
        chk("hold_nwen", 64'(wen_log.size()), 64'd1);

        // Redirect with two requests in flight.
        redirect_to(32'h8);
        chk("rd8_flush", {63'd0, last_flush}, 64'd1);
        clear_logs();
        rsp_en   = 1'b0;
        fetch_en = 1'b1;
        run(4);
        chk("rd_out_nreq", 64'(req_log.size()), 64'd2);
        chk("rd_out_req0", req_at(0), 64'h8);
        chk("rd_out_req1", req_at(1), 64'hC);
        clear_logs();
        redirect_to(32'h103);
        chk("rd_flush", {63'd0, last_flush}, 64'd1);
        chk("rd_nowen", {63'd0, last_wen}, 64'd0);
        rsp_en = 1'b1;
        cyc();
        chk("rd_flush_off", {63'd0, last_flush}, 64'd0);
        chk("rd_drop0", {63'd0, last_wen}, 64'd0);
        run(8);
        chk("rd_nflush", 64'(n_flush), 64'd1);
        chk("rd_req0", req_at(0), 64'h100);
        chk("rd_wen0", wen_at(0), ent(32'h100));
        chk("rd_wen1", wen_at(1), ent(32'h104));

        // Redirect coinciding with the only outstanding response.
        run(10);
        redirect_to(32'h40);
        clear_logs();
        run(2);
        redirect_vld = 1'b1;
        redirect_pc  = 32'h80;
        cyc();
        redirect_vld = 1'b0;
        chk("rv_rd_wen",   {63'd0, last_wen}, 64'd0);
        chk("rv_rd_flush", {63'd0, last_flush}, 64'd1);
        chk("rv_rd_req",   {63'd0, last_req}, 64'd0);
        run(6);
        chk("rv_req0", req_at(0), 64'h40);
        chk("rv_req1", req_at(1), 64'h80);
        chk("rv_wen0", wen_at(0), ent(32'h80));

        // Address wrap at the top of the space.
        run(10);
        redirect_to(32'hFFFF_FFFC);
        clear_logs();
        run(8);
        chk("wrap_req0", req_at(0), 64'hFFFF_FFFC);
        chk("wrap_req1", req_at(1), 64'h0);
        chk("wrap_wen0", wen_at(0), ent(32'hFFFF_FFFC));
        chk("wrap_wen1", wen_at(1), ent(32'h0));

        // Async reset with two requests outstanding.
        run(10);
        redirect_to(32'h300);
        clear_logs();
        rsp_en = 1'b0;
        run(4);
        chk("ar_req0", req_at(0), 64'h300);
        chk("ar_req1", req_at(1), 64'h304);
        #1;
        chk("ar_pre_addr", {32'd0, imem_addr}, 64'h308);
        #1;
        RST = 1'b1;
        pend.delete();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        #1;
        chk("ar_req",   {63'd0, imem_req}, 64'd0);
        chk("ar_addr",  {32'd0, imem_addr}, 64'd0);
        chk("ar_wen",   {63'd0, q_wen}, 64'd0);
        chk("ar_wdata", q_wdata, 64'd0);
        chk("ar_flush", {63'd0, q_flush}, 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        clear_logs();
        rsp_en = 1'b1;
        run(6);
        chk("ar_resume_req0", req_at(0), 64'h0);
        chk("ar_resume_wen0", wen_at(0), ent(32'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
